// File: rtl/dispatch_credit_ctrl_pkg.sv
// ============================================================================
// dispatch_credit_ctrl_pkg : shared types, widths and helpers -- Rev 1.0
// ============================================================================
`default_nettype none

package dispatch_credit_ctrl_pkg;

  localparam int DISPATCH_WIDTH = 4;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    BLOCKED = 2'd1,
    DRAIN   = 2'd2
  } state_e;

  function automatic int credit_w(input int size);
    return $clog2(size + 1);
  endfunction

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dispatch_credit_ctrl_if.sv
// ============================================================================
// dispatch_credit_ctrl_if : rename-side bundle and dispatch-side bundle -- Rev 1.0
// ============================================================================
`default_nettype none

interface dispatch_credit_ctrl_if #(
  parameter int PKT_W = 160
);

  logic             renameReady_i;
  logic [PKT_W-1:0] renamedPacket0_i;
  logic [PKT_W-1:0] renamedPacket1_i;
  logic [PKT_W-1:0] renamedPacket2_i;
  logic [PKT_W-1:0] renamedPacket3_i;
  logic [3:0]       isLoad_i;
  logic [3:0]       isStore_i;
  logic             stall_o;

  logic             dispatchReady_o;
  logic [PKT_W-1:0] dispatchPacket0_o;
  logic [PKT_W-1:0] dispatchPacket1_o;
  logic [PKT_W-1:0] dispatchPacket2_o;
  logic [PKT_W-1:0] dispatchPacket3_o;
  logic [2:0]       lqAlloc_o;
  logic [2:0]       sqAlloc_o;

  modport master (
    output renameReady_i, renamedPacket0_i, renamedPacket1_i,
           renamedPacket2_i, renamedPacket3_i, isLoad_i, isStore_i,
    input  stall_o, dispatchReady_o, dispatchPacket0_o, dispatchPacket1_o,
           dispatchPacket2_o, dispatchPacket3_o, lqAlloc_o, sqAlloc_o
  );

  modport slave (
    input  renameReady_i, renamedPacket0_i, renamedPacket1_i,
           renamedPacket2_i, renamedPacket3_i, isLoad_i, isStore_i,
    output stall_o, dispatchReady_o, dispatchPacket0_o, dispatchPacket1_o,
           dispatchPacket2_o, dispatchPacket3_o, lqAlloc_o, sqAlloc_o
  );

endinterface

`default_nettype wire

// File: rtl/dispatch_credit_ctrl_credit_counter.sv
// ============================================================================
// credit_counter : free-entry credit with used/release update and >=N compare -- Rev 1.0
// ============================================================================
`default_nettype none

module credit_counter #(
  parameter int SIZE = 32
) (
  input  wire logic                       clk,
  input  wire logic                       reset,
  input  wire logic                       flush_i,
  input  wire logic [2:0]                 used_i,
  input  wire logic [2:0]                 release_i,
  input  wire logic [2:0]                 need_i,
  output logic      [$clog2(SIZE+1)-1:0]  count_o,
  output logic                            enough_o
);

  localparam int         W      = $clog2(SIZE + 1);
  localparam logic [W:0] SIZE_C = (W+1)'(SIZE);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic [W:0]   sum;

  // used never exceeds the credit because dispatch is gated by enough_o
  always_comb begin
    sum     = {1'b0, count_q} + (W+1)'(release_i) - (W+1)'(used_i);
    count_d = (sum > SIZE_C) ? SIZE_C[W-1:0] : sum[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= W'(SIZE);
    end else if (flush_i) begin
      count_q <= W'(SIZE);
    end else begin
      assert (sum <= SIZE_C)
        else $error("credit_counter: release pushes credit above SIZE=%0d", SIZE);
      count_q <= count_d;
    end
  end

  assign count_o  = count_q;
  assign enough_o = ({1'b0, count_q} >= (W+1)'(need_i));

endmodule

`default_nettype wire

// File: rtl/dispatch_credit_ctrl.sv
// ============================================================================
// dispatch_credit_ctrl : credit-checked rename->dispatch register with flush drain.
// Optional stall statistics under DISPATCH_STALL_STATS_EN. Rev 1.0
// ============================================================================
`default_nettype none

module dispatch_credit_ctrl
  import dispatch_credit_ctrl_pkg::*;
#(
  parameter int PKT_W       = 160,
  parameter int IQ_SIZE     = 32,
  parameter int AL_SIZE     = 64,
  parameter int LQ_SIZE     = 16,
  parameter int SQ_SIZE     = 16,
  parameter int FLUSH_DRAIN = 3
) (
  input  wire logic                          clk,
  input  wire logic                          reset,
  input  wire logic                          flush_i,
  dispatch_credit_ctrl_if.slave              bus,
  input  wire logic [2:0]                    iqRelease_i,
  input  wire logic [2:0]                    alRelease_i,
  input  wire logic [2:0]                    lqRelease_i,
  input  wire logic [2:0]                    sqRelease_i,
  output logic [credit_w(IQ_SIZE)-1:0]       iqFree_o,
  output logic [credit_w(AL_SIZE)-1:0]       alFree_o,
  output logic [credit_w(LQ_SIZE)-1:0]       lqFree_o,
  output logic [credit_w(SQ_SIZE)-1:0]       sqFree_o
`ifdef DISPATCH_STALL_STATS_EN
  ,
  output logic [31:0]                        stallIq_o,
  output logic [31:0]                        stallAl_o,
  output logic [31:0]                        stallLq_o,
  output logic [31:0]                        stallSq_o
`endif
);

  localparam int       CNT_W    = (FLUSH_DRAIN > 1) ? $clog2(FLUSH_DRAIN) : 1;
  localparam logic [2:0] WIDTH_C = 3'(DISPATCH_WIDTH);

  state_e             state_q;
  logic [CNT_W-1:0]   drainCnt_q;
  logic               dispatchReady_q;
  logic [PKT_W-1:0]   pkt_q [DISPATCH_WIDTH];
  logic [2:0]         lqAlloc_q;
  logic [2:0]         sqAlloc_q;

  logic [2:0] nLd, nSt;
  logic       iqOk, alOk, lqOk, sqOk, fit;
  logic       dispatch, stall;

  assign nLd = popcount4(bus.isLoad_i);
  assign nSt = popcount4(bus.isStore_i);
  assign fit = iqOk && alOk && lqOk && sqOk;

  assign dispatch = !flush_i && (state_q != DRAIN) && bus.renameReady_i && fit;

  always_comb begin
    stall = 1'b0;
    case (state_q)
      RUN:     stall = bus.renameReady_i && !fit;
      BLOCKED: stall = !fit;
      DRAIN:   stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  credit_counter #(.SIZE(IQ_SIZE)) u_iq (
    .clk(clk), .reset(reset), .flush_i(flush_i),
    .used_i(dispatch ? WIDTH_C : 3'd0), .release_i(iqRelease_i), .need_i(WIDTH_C),
    .count_o(iqFree_o), .enough_o(iqOk)
  );

  credit_counter #(.SIZE(AL_SIZE)) u_al (
    .clk(clk), .reset(reset), .flush_i(flush_i),
    .used_i(dispatch ? WIDTH_C : 3'd0), .release_i(alRelease_i), .need_i(WIDTH_C),
    .count_o(alFree_o), .enough_o(alOk)
  );

  credit_counter #(.SIZE(LQ_SIZE)) u_lq (
    .clk(clk), .reset(reset), .flush_i(flush_i),
    .used_i(dispatch ? nLd : 3'd0), .release_i(lqRelease_i), .need_i(nLd),
    .count_o(lqFree_o), .enough_o(lqOk)
  );

  credit_counter #(.SIZE(SQ_SIZE)) u_sq (
    .clk(clk), .reset(reset), .flush_i(flush_i),
    .used_i(dispatch ? nSt : 3'd0), .release_i(sqRelease_i), .need_i(nSt),
    .count_o(sqFree_o), .enough_o(sqOk)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= RUN;
      drainCnt_q      <= '0;
      dispatchReady_q <= 1'b0;
      lqAlloc_q       <= 3'd0;
      sqAlloc_q       <= 3'd0;
      for (int i = 0; i < DISPATCH_WIDTH; i++) pkt_q[i] <= '0;
    end else if (flush_i) begin
      state_q         <= DRAIN;
      drainCnt_q      <= CNT_W'(FLUSH_DRAIN - 1);
      dispatchReady_q <= 1'b0;
      lqAlloc_q       <= 3'd0;
      sqAlloc_q       <= 3'd0;
      for (int i = 0; i < DISPATCH_WIDTH; i++) pkt_q[i] <= '0;
    end else begin
      dispatchReady_q <= dispatch;
      // packets only move on dispatch so they hold while the valid flag is low
      if (dispatch) begin
        pkt_q[0]  <= bus.renamedPacket0_i;
        pkt_q[1]  <= bus.renamedPacket1_i;
        pkt_q[2]  <= bus.renamedPacket2_i;
        pkt_q[3]  <= bus.renamedPacket3_i;
        lqAlloc_q <= nLd;
        sqAlloc_q <= nSt;
      end
      case (state_q)
        RUN: begin
          if (bus.renameReady_i && !fit) state_q <= BLOCKED;
        end
        BLOCKED: begin
          if (!bus.renameReady_i || fit) state_q <= RUN;
        end
        DRAIN: begin
          if (drainCnt_q == '0) state_q <= RUN;
          else                  drainCnt_q <= drainCnt_q - 1'b1;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign bus.stall_o           = stall;
  assign bus.dispatchReady_o   = dispatchReady_q;
  assign bus.dispatchPacket0_o = pkt_q[0];
  assign bus.dispatchPacket1_o = pkt_q[1];
  assign bus.dispatchPacket2_o = pkt_q[2];
  assign bus.dispatchPacket3_o = pkt_q[3];
  assign bus.lqAlloc_o         = lqAlloc_q;
  assign bus.sqAlloc_o         = sqAlloc_q;

`ifdef DISPATCH_STALL_STATS_EN
  logic [31:0] stallIq_q, stallAl_q, stallLq_q, stallSq_q;
  logic        statHit;

  // flush does not clear the statistics
  assign statHit = stall && (state_q != DRAIN);

  always_ff @(posedge clk) begin
    if (reset) begin
      stallIq_q <= '0;
      stallAl_q <= '0;
      stallLq_q <= '0;
      stallSq_q <= '0;
    end else if (statHit) begin
      if (!iqOk && stallIq_q != '1) stallIq_q <= stallIq_q + 32'd1;
      if (!alOk && stallAl_q != '1) stallAl_q <= stallAl_q + 32'd1;
      if (!lqOk && stallLq_q != '1) stallLq_q <= stallLq_q + 32'd1;
      if (!sqOk && stallSq_q != '1) stallSq_q <= stallSq_q + 32'd1;
    end
  end

  assign stallIq_o = stallIq_q;
  assign stallAl_o = stallAl_q;
  assign stallLq_o = stallLq_q;
  assign stallSq_o = stallSq_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dispatch_credit_ctrl.sv
// ============================================================================
// tb_dispatch_credit_ctrl : directed self-checking bench for dispatch_credit_ctrl -- Rev 1.0
// ============================================================================
`default_nettype none

module tb_dispatch_credit_ctrl;

  localparam int PKT_W = 160;

  logic clk;
  logic reset;
  logic flush_i;
  logic [2:0] iqRelease, alRelease, lqRelease, sqRelease;
  logic [5:0] iqFree;
  logic [6:0] alFree;
  logic [4:0] lqFree;
  logic [4:0] sqFree;
`ifdef DISPATCH_STALL_STATS_EN
  logic [31:0] stallIq, stallAl, stallLq, stallSq;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  dispatch_credit_ctrl_if #(.PKT_W(PKT_W)) bus ();

  dispatch_credit_ctrl #(
    .PKT_W(PKT_W), .IQ_SIZE(32), .AL_SIZE(64), .LQ_SIZE(16), .SQ_SIZE(16), .FLUSH_DRAIN(3)
  ) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i), .bus(bus.slave),
    .iqRelease_i(iqRelease), .alRelease_i(alRelease),
    .lqRelease_i(lqRelease), .sqRelease_i(sqRelease),
    .iqFree_o(iqFree), .alFree_o(alFree), .lqFree_o(lqFree), .sqFree_o(sqFree)
`ifdef DISPATCH_STALL_STATS_EN
    ,
    .stallIq_o(stallIq), .stallAl_o(stallAl), .stallLq_o(stallLq), .stallSq_o(stallSq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rr, input logic [3:0] ld, input logic [3:0] st,
                       input logic [2:0] iqr, input logic [2:0] alr,
                       input logic [2:0] lqr, input logic [2:0] sqr);
    bus.renameReady_i = rr;
    bus.isLoad_i      = ld;
    bus.isStore_i     = st;
    iqRelease         = iqr;
    alRelease         = alr;
    lqRelease         = lqr;
    sqRelease         = sqr;
    #1;
  endtask

  task automatic set_pkts(input logic [31:0] base);
    bus.renamedPacket0_i = {5{base}};
    bus.renamedPacket1_i = {5{base + 32'd1}};
    bus.renamedPacket2_i = {5{base + 32'd2}};
    bus.renamedPacket3_i = {5{base + 32'd3}};
  endtask

  initial begin
    reset   = 1'b1;
    flush_i = 1'b0;
    set_pkts(32'h0);
    drive(1'b0, 4'b0, 4'b0, 3'd0, 3'd0, 3'd0, 3'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;

    // Reset state
    chk("rst_ready", 160'(bus.dispatchReady_o), 160'd0);
    chk("rst_iq",    160'(iqFree), 160'd32);
    chk("rst_al",    160'(alFree), 160'd64);
    chk("rst_lq",    160'(lqFree), 160'd16);
    chk("rst_sq",    160'(sqFree), 160'd16);
    chk("rst_lqalloc", 160'(bus.lqAlloc_o), 160'd0);
    chk("rst_pkt0",  bus.dispatchPacket0_o, 160'd0);
    chk("rst_stall", 160'(bus.stall_o), 160'd0);

    // First bundle: 2 loads, 1 store
    set_pkts(32'hA000_0000);
    drive(1'b1, 4'b0011, 4'b0100, 3'd0, 3'd0, 3'd0, 3'd0);
    chk("b1_stall", 160'(bus.stall_o), 160'd0);
    tick();
    drive(1'b0, 4'b0, 4'b0, 3'd0, 3'd0, 3'd0, 3'd0);
    chk("b1_ready", 160'(bus.dispatchReady_o), 160'd1);
    chk("b1_iq", 160'(iqFree), 160'd28);
    chk("b1_al", 160'(alFree), 160'd60);
    chk("b1_lq", 160'(lqFree), 160'd14);
    chk("b1_sq", 160'(sqFree), 160'd15);
    chk("b1_lqalloc", 160'(bus.lqAlloc_o), 160'd2);
    chk("b1_sqalloc", 160'(bus.sqAlloc_o), 160'd1);
    chk("b1_pkt0", bus.dispatchPacket0_o, {5{32'hA000_0000}});
    chk("b1_pkt3", bus.dispatchPacket3_o, {5{32'hA000_0003}});
    tick();
    chk("idle_ready", 160'(bus.dispatchReady_o), 160'd0);
    chk("idle_pkt_hold", bus.dispatchPacket0_o, {5{32'hA000_0000}});

    // Walk AL down to 3 with IQ held at 28
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, 4'b0, 4'b0, 3'd4, (i == 14) ? 3'd3 : 3'd0, 3'd0, 3'd0);
      tick();
    end
    chk("al3_al", 160'(alFree), 160'd3);
    chk("al3_iq", 160'(iqFree), 160'd28);
    drive(1'b1, 4'b0, 4'b0, 3'd0, 3'd0, 3'd0, 3'd0);
    chk("al3_stall", 160'(bus.stall_o), 160'd1);
    tick();
    chk("al3_blk_ready", 160'(bus.dispatchReady_o), 160'd0);
    drive(1'b1, 4'b0, 4'b0, 3'd0, 3'd1, 3'd0, 3'd0);
    chk("al3_blk_stall", 160'(bus.stall_o), 160'd1);
    tick();
    chk("al4_al", 160'(alFree), 160'd4);
    drive(1'b1, 4'b0, 4'b0, 3'd0, 3'd0, 3'd0, 3'd0);
    chk("al4_stall", 160'(bus.stall_o), 160'd0);
    tick();
    chk("al0_ready", 160'(bus.dispatchReady_o), 160'd1);
    chk("al0_al", 160'(alFree), 160'd0);
    chk("al0_iq", 160'(iqFree), 160'd24);

    // Refill AL and IQ with rename idle
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 4'b0, 4'b0, (i < 2) ? 3'd4 : 3'd0, 3'd4, 3'd0, 3'd0);
      tick();
    end
    chk("refill_al", 160'(alFree), 160'd64);
    chk("refill_iq", 160'(iqFree), 160'd32);

    // Walk LQ down to 1 (14 -> 10 -> 6 -> 2 -> 1)
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, (i < 3) ? 4'b1111 : 4'b0001, 4'b0, 3'd4, 3'd4, 3'd0, 3'd0);
      tick();
    end
    chk("lq1_lq", 160'(lqFree), 160'd1);
    chk("lq1_iq", 160'(iqFree), 160'd32);

    // Same-cycle release is not counted toward fit
    drive(1'b1, 4'b0011, 4'b0, 3'd0, 3'd0, 3'd4, 3'd0);
    chk("lqrel_stall", 160'(bus.stall_o), 160'd1);
    tick();
    chk("lqrel_lq", 160'(lqFree), 160'd5);
    chk("lqrel_ready", 160'(bus.dispatchReady_o), 160'd0);
    drive(1'b1, 4'b0011, 4'b0, 3'd0, 3'd0, 3'd0, 3'd0);
    chk("lq5_stall", 160'(bus.stall_o), 160'd0);
    tick();
    chk("lq3_ready", 160'(bus.dispatchReady_o), 160'd1);
    chk("lq3_lq", 160'(lqFree), 160'd3);
    chk("lq3_lqalloc", 160'(bus.lqAlloc_o), 160'd2);

    // IQ 28 -> 10, then dispatch with simultaneous release of 4
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'b0, 4'b0, (i == 4) ? 3'd2 : 3'd0, 3'd4, 3'd0, 3'd0);
      tick();
    end
    chk("iq10_iq", 160'(iqFree), 160'd10);
    chk("iq10_al", 160'(alFree), 160'd60);
    drive(1'b1, 4'b0, 4'b0, 3'd4, 3'd4, 3'd0, 3'd0);
    tick();
    chk("iqsim_iq", 160'(iqFree), 160'd10);
    chk("iqsim_ready", 160'(bus.dispatchReady_o), 160'd1);

    // IQ 10 -> 2, block, then flush
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 4'b0, 4'b0, 3'd0, 3'd4, 3'd0, 3'd0);
      tick();
    end
    chk("iq2_iq", 160'(iqFree), 160'd2);
    drive(1'b1, 4'b0, 4'b0, 3'd0, 3'd0, 3'd0, 3'd0);
    chk("iq2_stall", 160'(bus.stall_o), 160'd1);
    tick();
    chk("blk_stall", 160'(bus.stall_o), 160'd1);
    chk("blk_ready", 160'(bus.dispatchReady_o), 160'd0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    #1;
    chk("fl_iq", 160'(iqFree), 160'd32);
    chk("fl_al", 160'(alFree), 160'd64);
    chk("fl_lq", 160'(lqFree), 160'd16);
    chk("fl_sq", 160'(sqFree), 160'd16);
    chk("fl_pkt0", bus.dispatchPacket0_o, 160'd0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("drain%0d_stall", i), 160'(bus.stall_o), 160'd1);
      chk($sformatf("drain%0d_ready", i), 160'(bus.dispatchReady_o), 160'd0);
      tick();
    end
    chk("drain_iq", 160'(iqFree), 160'd32);
    chk("post_drain_stall", 160'(bus.stall_o), 160'd0);
    tick();
    chk("post_drain_ready", 160'(bus.dispatchReady_o), 160'd1);
    chk("post_drain_iq", 160'(iqFree), 160'd28);

    // Reset mid-operation
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1'b0, 4'b0, 4'b0, 3'd0, 3'd0, 3'd0, 3'd0);
    chk("mrst_ready", 160'(bus.dispatchReady_o), 160'd0);
    chk("mrst_iq", 160'(iqFree), 160'd32);
    chk("mrst_pkt0", bus.dispatchPacket0_o, 160'd0);
    chk("mrst_lqalloc", 160'(bus.lqAlloc_o), 160'd0);

    // SQ 16 -> 0 and IQ 32 -> 2
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 4'b0, (i < 4) ? 4'b1111 : 4'b0000, (i == 7) ? 3'd2 : 3'd0,
            3'd0, 3'd0, 3'd0);
      tick();
    end
    chk("starve_iq", 160'(iqFree), 160'd2);
    chk("starve_sq", 160'(sqFree), 160'd0);
    chk("starve_al", 160'(alFree), 160'd32);
    drive(1'b1, 4'b0, 4'b0001, 3'd0, 3'd0, 3'd0, 3'd0);
    for (int i = 0; i < 5; i++) tick();
    drive(1'b0, 4'b0, 4'b0, 3'd0, 3'd0, 3'd0, 3'd0);
    chk("starve_ready", 160'(bus.dispatchReady_o), 160'd0);
`ifdef DISPATCH_STALL_STATS_EN
    chk("stat_iq", 160'(stallIq), 160'd5);
    chk("stat_sq", 160'(stallSq), 160'd5);
    chk("stat_al", 160'(stallAl), 160'd0);
    chk("stat_lq", 160'(stallLq), 160'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
